// File: rtl/serv_mdu_pkg.sv
// serv_mdu_pkg: shared constants for the sequential RV32M multiply/divide unit.
//   XLEN         datapath width (32)
//   OP_*         funct3 opcode encodings
//   S_*          FSM state encoding for serv_mdu_seq
//   DIV0_QUOT    quotient returned for a division by zero
//   op_signed_a/op_signed_b  which opcodes treat rs1/rs2 as two's complement
package serv_mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [XLEN-1:0] DIV0_QUOT = {XLEN{1'b1}};

  // MUL is handled as an unsigned product, so only the high-word and
  // signed-divide opcodes see signed operands.
  function automatic logic op_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/serv_mdu_addsub.sv
// serv_mdu_addsub: 33-bit adder/subtractor shared by every arithmetic step of
// the MDU (operand negation, shift-add, restoring trial subtract, result fix-up).
//   a, b  in  33  operands
//   sub   in  1   1: a - b, 0: a + b
//   sum   out 33  result
//   cout  out 1   carry out; for subtraction 1 means no borrow (a >= b)
module serv_mdu_addsub
  import serv_mdu_pkg::*;
(
  input  logic [XLEN:0] a,
  input  logic [XLEN:0] b,
  input  logic          sub,
  output logic [XLEN:0] sum,
  output logic          cout
);

  logic [XLEN+1:0] full;

  assign full = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{(XLEN+1){1'b0}}, sub};
  assign sum  = full[XLEN:0];
  assign cout = full[XLEN+1];

endmodule

// File: rtl/serv_mdu_seq.sv
// serv_mdu_seq: sequential radix-2 RV32M multiply/divide unit for the
// bit-serial core. A request is captured in IDLE; 35 cycles later the result
// is presented on o_mdu_rd together with a one-cycle o_mdu_ready pulse.
//   clk           core clock
//   i_rst         asynchronous active-high reset
//   i_mdu_valid   request (sampled only in IDLE)
//   i_mdu_opcode  funct3 of the M-extension instruction
//   i_mdu_rs1     operand A (multiplicand / dividend)
//   i_mdu_rs2     operand B (multiplier / divisor)
//   o_mdu_ready   one-cycle completion pulse
//   o_mdu_rd      result, held until the next completion
// Configuration: define SERV_MDU_DIV_EN to build the divider; without it
// opcodes 4-7 run through the same FSM and return 0.
module serv_mdu_seq
  import serv_mdu_pkg::*;
(
  input  logic            clk,
  input  logic            i_rst,
  input  logic            i_mdu_valid,
  input  logic [2:0]      i_mdu_opcode,
  input  logic [XLEN-1:0] i_mdu_rs1,
  input  logic [XLEN-1:0] i_mdu_rs2,
  output logic            o_mdu_ready,
  output logic [XLEN-1:0] o_mdu_rd
);

  logic [2:0]      state;
  logic [4:0]      cnt;
  logic [2:0]      op_q;
  logic [XLEN-1:0] rs1_q;    // raw dividend, needed for REM by zero
  logic [XLEN-1:0] a_q;      // |A|
  logic [XLEN-1:0] b_q;      // |B|
  logic            sb_q;     // B was negative and signed
  logic            neg_res;
  logic [XLEN:0]   acc;      // mul: high partial product, div: remainder
  logic [XLEN-1:0] mq;       // mul: multiplier / low product, div: quotient

  logic [XLEN:0]   add_a, add_b, add_sum;
  logic            add_sub, add_cout;

  logic            is_div, sign_a, sign_b_in;
  logic [XLEN-1:0] a_mag, fix_sel, fix_res;
  logic            fix_cin, neg_res_d;

  assign is_div    = op_q[2];
  assign sign_a    = rs1_q[XLEN-1] & op_signed_a(op_q);
  assign sign_b_in = i_mdu_rs2[XLEN-1] & op_signed_b(i_mdu_opcode);
  assign a_mag     = sign_a ? add_sum[XLEN-1:0] : rs1_q;

  always_comb begin
    neg_res_d = 1'b0;
    case (op_q)
      OP_MULH, OP_MULHSU, OP_DIV: neg_res_d = sign_a ^ sb_q;
      OP_REM:                     neg_res_d = sign_a;
      default:                    neg_res_d = 1'b0;
    endcase
  end

  // A negated 64-bit product only carries into the high word when the low
  // word is zero, so the high-word fix-up is ~hi + (lo == 0).
  always_comb begin
    if (is_div)
      fix_sel = op_q[1] ? acc[XLEN-1:0] : mq;
    else
      fix_sel = (op_q == OP_MUL) ? mq : acc[XLEN-1:0];
    fix_cin = is_div | (mq == '0);
  end

  // Every negation is done as ~x + cin on the shared adder. B is negated
  // while the request is captured, since the adder is otherwise idle then and
  // INIT needs it for A.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    case (state)
      S_IDLE: begin
        add_a = {1'b0, ~i_mdu_rs2};
        add_b = {{XLEN{1'b0}}, 1'b1};
      end
      S_INIT: begin
        add_a = {1'b0, ~rs1_q};
        add_b = {{XLEN{1'b0}}, 1'b1};
      end
      S_RUN: begin
        if (!is_div) begin
          add_a = acc;
          add_b = mq[0] ? {1'b0, a_q} : '0;
        end
`ifdef SERV_MDU_DIV_EN
        else begin
          add_a   = {acc[XLEN-1:0], mq[XLEN-1]};
          add_b   = {1'b0, b_q};
          add_sub = 1'b1;
        end
`endif
      end
      S_FIX: begin
        add_a = {1'b0, ~fix_sel};
        add_b = {{XLEN{1'b0}}, fix_cin};
      end
      default: ;
    endcase
  end

  serv_mdu_addsub u_addsub (
    .a    (add_a),
    .b    (add_b),
    .sub  (add_sub),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    fix_res = neg_res ? add_sum[XLEN-1:0] : fix_sel;
    if (is_div) begin
`ifdef SERV_MDU_DIV_EN
      // Division by zero bypasses sign correction entirely.
      if (b_q == '0)
        fix_res = op_q[1] ? rs1_q : DIV0_QUOT;
`else
      fix_res = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= '0;
      rs1_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sb_q        <= 1'b0;
      neg_res     <= 1'b0;
      acc         <= '0;
      mq          <= '0;
      o_mdu_ready <= 1'b0;
      o_mdu_rd    <= '0;
    end else begin
      o_mdu_ready <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_mdu_valid) begin
            op_q  <= i_mdu_opcode;
            rs1_q <= i_mdu_rs1;
            sb_q  <= sign_b_in;
            b_q   <= sign_b_in ? add_sum[XLEN-1:0] : i_mdu_rs2;
            state <= S_INIT;
          end
        end
        S_INIT: begin
          a_q     <= a_mag;
          acc     <= '0;
          mq      <= is_div ? a_mag : b_q;
          neg_res <= neg_res_d;
          cnt     <= '0;
          state   <= S_RUN;
        end
        S_RUN: begin
          cnt <= cnt + 5'd1;
          if (!is_div) begin
            // Carry out is shifted in so the 33-bit partial sum is never truncated.
            acc <= {add_cout, add_sum[XLEN:1]};
            mq  <= {add_sum[0], mq[XLEN-1:1]};
          end
`ifdef SERV_MDU_DIV_EN
          else begin
            if (add_cout)
              acc <= {1'b0, add_sum[XLEN-1:0]};
            else
              acc <= {acc[XLEN-1:0], mq[XLEN-1]};
            mq <= {mq[XLEN-2:0], add_cout};
          end
`endif
          if (cnt == 5'd31)
            state <= S_FIX;
        end
        S_FIX: begin
          o_mdu_rd    <= fix_res;
          o_mdu_ready <= 1'b1;
          state       <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serv_mdu_seq.sv
// tb_serv_mdu_seq: self-checking bench for serv_mdu_seq. Results are predicted
// from 64-bit integer arithmetic following the RV32M rules.
module tb_serv_mdu_seq;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_mdu_valid;
  logic [2:0]  i_mdu_opcode;
  logic [31:0] i_mdu_rs1;
  logic [31:0] i_mdu_rs2;
  logic        o_mdu_ready;
  logic [31:0] o_mdu_rd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serv_mdu_seq dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_mdu_valid  (i_mdu_valid),
    .i_mdu_opcode (i_mdu_opcode),
    .i_mdu_rs1    (i_mdu_rs1),
    .i_mdu_rs2    (i_mdu_rs2),
    .o_mdu_ready  (o_mdu_ready),
    .o_mdu_rd     (o_mdu_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub, q;
    logic [63:0] p;
    logic [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    r  = '0;
    case (op)
      3'd0: begin p = ua * ub; r = p[31:0];  end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
`ifdef SERV_MDU_DIV_EN
      3'd4: begin if (b == 0) r = 32'hFFFF_FFFF; else begin q = sa / sb; r = q[31:0]; end end
      3'd5: begin if (b == 0) r = 32'hFFFF_FFFF; else begin q = ua / ub; r = q[31:0]; end end
      3'd6: begin if (b == 0) r = a; else begin q = sa % sb; r = q[31:0]; end end
      3'd7: begin if (b == 0) r = a; else begin q = ua % ub; r = q[31:0]; end end
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // One request from a known-IDLE unit. Valid is raised just after an edge, so
  // the next edge is the capture edge N. Ready must then be high in the cycle
  // that ends at edge N+35, i.e. observed just after the 34th edge following N.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit hold);
    logic [31:0] exp;
    int          lat;
    exp          = model(op, a, b);
    i_mdu_valid  = 1'b1;
    i_mdu_opcode = op;
    i_mdu_rs1    = a;
    i_mdu_rs2    = b;
    @(posedge clk); #1;
    // Operands must not be resampled after capture.
    i_mdu_rs1    = $urandom;
    i_mdu_rs2    = $urandom;
    i_mdu_opcode = 3'($urandom_range(0, 7));
    if (!hold) i_mdu_valid = 1'b0;
    lat = 0;
    while (!o_mdu_ready && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd34);
    chk({tag, "_rd"}, o_mdu_rd, exp);
    @(posedge clk); #1;
    i_mdu_valid = 1'b0;
    chk({tag, "_ready_pulse"}, {31'b0, o_mdu_ready}, 32'd0);
    chk({tag, "_rd_hold"}, o_mdu_rd, exp);
  endtask

  logic [31:0] special [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                               32'h7FFF_FFFF, 32'h2};

  initial begin
    logic [31:0] ra, rb;
    logic [2:0]  rop;
    i_rst        = 1'b1;
    i_mdu_valid  = 1'b0;
    i_mdu_opcode = '0;
    i_mdu_rs1    = '0;
    i_mdu_rs2    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {31'b0, o_mdu_ready}, 32'd0);
    chk("reset_rd", o_mdu_rd, 32'd0);
    i_rst = 1'b0;
    @(posedge clk); #1;

    run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("mul_ff",   3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    run_op("mulh_m1x2",   3'd1, 32'hFFFF_FFFF, 32'h2, 1'b1);
    run_op("mulhsu_m1x2", 3'd2, 32'hFFFF_FFFF, 32'h2, 1'b0);
    run_op("div_m7_2",  3'd4, 32'hFFFF_FFF9, 32'h2, 1'b1);
    run_op("rem_m7_2",  3'd6, 32'hFFFF_FFF9, 32'h2, 1'b1);
    run_op("divu_7_2",  3'd5, 32'h7, 32'h2, 1'b1);
    run_op("remu_7_2",  3'd7, 32'h7, 32'h2, 1'b1);
    run_op("div_by0",   3'd4, 32'h1234_5678, 32'h0, 1'b1);
    run_op("rem_by0",   3'd6, 32'h1234_5678, 32'h0, 1'b1);
    run_op("div_ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("rem_ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op("mulh_neg",  3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op("mulh_mixed", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);

    // Leave a nonzero result, then reset in the middle of RUN.
    run_op("pre_reset", 3'd0, 32'd6, 32'd7, 1'b1);
    i_mdu_valid  = 1'b1;
    i_mdu_opcode = 3'd0;
    i_mdu_rs1    = 32'd9;
    i_mdu_rs2    = 32'd9;
    @(posedge clk); #1;
    i_mdu_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    i_rst = 1'b1;
    #1;
    chk("midrst_ready", {31'b0, o_mdu_ready}, 32'd0);
    chk("midrst_rd", o_mdu_rd, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      chk("after_rst_no_ready", {31'b0, o_mdu_ready}, 32'd0);
    end
    run_op("mul_3x5", 3'd0, 32'd3, 32'd5, 1'b1);

    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 5)] : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
      run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
